// File: rtl/ppu_palette_ram.sv
// CPU-writable palette RAM with NES backdrop mirroring, NUM_PORTS registered read ports,
// a self-clearing init sequence and a post-lookup brightness stage driven by a fade engine.
module ppu_palette_ram #(
    parameter int ENTRIES   = 32,
    parameter int COLOR_W   = 24,
    parameter int NUM_PORTS = 2,
    parameter int MIRROR    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           palette_en,
    input  logic [NUM_PORTS*$clog2(ENTRIES)-1:0] rd_addr,
    output logic [NUM_PORTS*COLOR_W-1:0]   color_out,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [$clog2(ENTRIES)-1:0]     wr_addr,
    input  logic [COLOR_W-1:0]             wr_data,
    output logic                           init_done,
    input  logic                           fade_start,
    input  logic [3:0]                     fade_target,
    input  logic [15:0]                    fade_period,
    output logic [3:0]                     brightness,
    output logic                           fade_busy
);
    localparam int   AW        = $clog2(ENTRIES);
    localparam int   CW        = COLOR_W / 3;
    localparam logic MIRROR_EN = (MIRROR != 0);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

    // Backdrop entries (MSB set, low two bits clear) alias their MSB-cleared twin.
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = a;
        if (MIRROR_EN && a[AW-1] && (a[1:0] == 2'b00)) begin
            m[AW-1] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c, input logic [3:0] b);
        logic [COLOR_W-1:0] res;
        logic [CW+4:0]      prod;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            prod = (CW+5)'(c[ch*CW +: CW]) * (CW+5)'({1'b0, b} + 5'd1);
            res[ch*CW +: CW] = prod[CW+3:4];
        end
        return res;
    endfunction

    state_t                 state_r;
    logic [AW-1:0]          clr_cnt_r;
    logic [COLOR_W-1:0]     mem_r [ENTRIES];
    logic [COLOR_W-1:0]     s1_data_r [NUM_PORTS];
    logic                   s1_en_r;
    logic                   s1_idle_r;
    logic [3:0]             s1_bright_r;
    logic [NUM_PORTS*COLOR_W-1:0] color_r;
    logic [3:0]             bright_r;
    logic [3:0]             target_r;
    logic [3:0]             bright_next_s;
    logic [15:0]            div_r;
    logic                   busy_r;

    assign wr_ready   = (state_r == ST_IDLE);
    assign init_done  = (state_r == ST_IDLE);
    assign color_out  = color_r;
    assign brightness = bright_r;
    assign fade_busy  = busy_r;

    // Control FSM: clear every entry once after reset, then accept writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_INIT;
            clr_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    clr_cnt_r <= clr_cnt_r + 1'b1;
                    if (clr_cnt_r == AW'(ENTRIES - 1)) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: state_r <= ST_IDLE;
                default: state_r <= ST_INIT;
            endcase
        end
    end

    // Palette storage: clear pass during INIT, CPU writes in IDLE.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (wr_valid) begin
            mem_r[map_addr(wr_addr)] <= wr_data;
        end
    end

    // Read stage 1: lookup plus the qualifiers and brightness used by stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                s1_data_r[p] <= '0;
            end
            s1_en_r     <= 1'b0;
            s1_idle_r   <= 1'b0;
            s1_bright_r <= 4'd15;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                s1_data_r[p] <= mem_r[map_addr(rd_addr[p*AW +: AW])];
            end
            s1_en_r     <= palette_en;
            s1_idle_r   <= (state_r == ST_IDLE);
            s1_bright_r <= bright_r;
        end
    end

    // Read stage 2: brightness scaling, blanked when the read was not qualified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_r <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                color_r[p*COLOR_W +: COLOR_W] <= (s1_en_r && s1_idle_r) ?
                                                 scale(s1_data_r[p], s1_bright_r) : '0;
            end
        end
    end

    // Next brightness level one step toward the target.
    always_comb begin
        bright_next_s = bright_r;
        if (target_r > bright_r) begin
            bright_next_s = bright_r + 4'd1;
        end else if (target_r < bright_r) begin
            bright_next_s = bright_r - 4'd1;
        end else begin
            bright_next_s = bright_r;
        end
    end

    // Fade engine: one brightness step every fade_period+1 cycles while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright_r <= 4'd15;
            target_r <= 4'd15;
            div_r    <= 16'd0;
            busy_r   <= 1'b0;
        end else if (fade_start) begin
            target_r <= fade_target;
            div_r    <= 16'd0;
            busy_r   <= (fade_target != bright_r);
        end else if (busy_r) begin
            if (div_r == fade_period) begin
                div_r    <= 16'd0;
                bright_r <= bright_next_s;
                if (bright_next_s == target_r) begin
                    busy_r <= 1'b0;
                end
            end else begin
                div_r <= div_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ppu_palette_ram.sv
// Self-checking bench for ppu_palette_ram: directed vectors, a cycle model compared every
// negedge, and literal expectations for the headline cases.
module tb_ppu_palette_ram;
    localparam int ENTRIES = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        palette_en;
    logic [9:0]  rd_addr;
    logic [47:0] color_out, color_out0;
    logic        wr_valid;
    logic        wr_ready, wr_ready0;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;
    logic        init_done, init_done0;
    logic        fade_start;
    logic [3:0]  fade_target;
    logic [15:0] fade_period;
    logic [3:0]  brightness, brightness0;
    logic        fade_busy, fade_busy0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ppu_palette_ram #(.ENTRIES(32), .COLOR_W(24), .NUM_PORTS(2), .MIRROR(1)) dut (
        .clk(clk), .rst(rst), .palette_en(palette_en), .rd_addr(rd_addr),
        .color_out(color_out), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done),
        .fade_start(fade_start), .fade_target(fade_target), .fade_period(fade_period),
        .brightness(brightness), .fade_busy(fade_busy));

    ppu_palette_ram #(.ENTRIES(32), .COLOR_W(24), .NUM_PORTS(2), .MIRROR(0)) dut0 (
        .clk(clk), .rst(rst), .palette_en(palette_en), .rd_addr(rd_addr),
        .color_out(color_out0), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done0),
        .fade_start(fade_start), .fade_target(fade_target), .fade_period(fade_period),
        .brightness(brightness0), .fade_busy(fade_busy0));

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] mem_m [ENTRIES];
    logic [23:0] pipe_m [2];
    logic [23:0] exp_m [2];
    int cnt_m;
    int f_from, f_to, f_per, f_k, bright_m;

    function automatic int mmap(input int a);
        return (a >= ENTRIES / 2 && a % 4 == 0) ? a - ENTRIES / 2 : a;
    endfunction

    function automatic logic [23:0] mscale(input logic [23:0] c, input int b);
        int r, g, bl;
        r  = int'(c[23:16]) * (b + 1) / 16;
        g  = int'(c[15:8])  * (b + 1) / 16;
        bl = int'(c[7:0])   * (b + 1) / 16;
        return {8'(r), 8'(g), 8'(bl)};
    endfunction

    function automatic int level(input int from, input int to, input int steps);
        int d;
        d = (to > from) ? to - from : from - to;
        if (steps > d) steps = d;
        return (to > from) ? from + steps : from - steps;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_m = 0;
            for (int i = 0; i < ENTRIES; i++) mem_m[i] = 24'h0;
            pipe_m[0] = 24'h0; pipe_m[1] = 24'h0;
            exp_m[0] = 24'h0;  exp_m[1] = 24'h0;
            f_from = 15; f_to = 15; f_per = 0; f_k = 0; bright_m = 15;
        end else begin
            automatic bit idle_b = (cnt_m >= ENTRIES);
            for (int p = 0; p < 2; p++) begin
                exp_m[p]  = pipe_m[p];
                pipe_m[p] = (palette_en && idle_b) ?
                            mscale(mem_m[mmap(int'(rd_addr[p*5 +: 5]))], bright_m) : 24'h0;
            end
            if (wr_valid && idle_b) mem_m[mmap(int'(wr_addr))] = wr_data;
            if (cnt_m < ENTRIES) cnt_m++;
            if (fade_start) begin
                f_from = bright_m; f_to = int'(fade_target); f_per = int'(fade_period); f_k = 0;
            end else begin
                f_k++;
            end
            bright_m = level(f_from, f_to, f_k / (f_per + 1));
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("port0", {24'h0, color_out[23:0]},  {24'h0, exp_m[0]});
        chk("port1", {24'h0, color_out[47:24]}, {24'h0, exp_m[1]});
        chk("wr_ready",  {47'h0, wr_ready},  {47'h0, cnt_m >= ENTRIES});
        chk("init_done", {47'h0, init_done}, {47'h0, cnt_m >= ENTRIES});
        chk("brightness", {44'h0, brightness}, {44'h0, 4'(bright_m)});
        chk("fade_busy", {47'h0, fade_busy}, {47'h0, bright_m != f_to});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [23:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        repeat (3) tick();
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!wr_ready && n < 40) begin
            wr_valid = (n < 5); wr_addr = 5'd3; wr_data = 24'hAAAAAA;
            tick();
            n++;
        end
        wr_valid = 1'b0;
        chk("init_cycles", 48'(n), 48'd32);
    endtask

    task automatic run_fade(input logic [3:0] tgt, input logic [15:0] per, output int n);
        fade_target = tgt; fade_period = per; fade_start = 1'b1;
        tick();
        fade_start = 1'b0;
        n = 0;
        while (fade_busy && n < 200) begin
            tick();
            n++;
            if (n == 4 && per == 16'd3) chk("fade_step1", {44'h0, brightness}, 48'd14);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; palette_en = 1'b0; rd_addr = 10'h0; wr_valid = 1'b0; wr_addr = 5'h0;
        wr_data = 24'h0; fade_start = 1'b0; fade_target = 4'd0; fade_period = 16'd0;
        repeat (3) tick();
        chk("rst_bright", {44'h0, brightness}, 48'd15);
        chk("rst_color", color_out, 48'h0);
        rst = 1'b0;
        chk("init_ready0", {47'h0, wr_ready}, 48'd0);
        wait_init();
        palette_en = 1'b1;
        rd2(5'd3, 5'd7);
        chk("init_write_dropped", color_out, 48'h0);

        wr1(5'd3, 24'h0000FF);
        wr1(5'd7, 24'hFF0000);
        rd2(5'd3, 5'd7);
        chk("rd_p0", {24'h0, color_out[23:0]},  48'h0000FF);
        chk("rd_p1", {24'h0, color_out[47:24]}, 48'hFF0000);

        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(8 + i); wr_data = {8'(i), 8'hA5, 8'(i * 3)};
            tick();
        end
        wr_valid = 1'b0;
        rd_addr = {5'd9, 5'd8}; tick();
        rd_addr = {5'd11, 5'd10}; tick();
        chk("b2b_8_9", color_out, {24'h01A503, 24'h00A500});
        tick();
        chk("b2b_10_11", color_out, {24'h03A509, 24'h02A506});

        wr1(5'h14, 24'h123456);
        wr1(5'h15, 24'hABCDEF);
        rd2(5'h04, 5'h05);
        chk("mirror_04", {24'h0, color_out[23:0]}, 48'h123456);
        chk("mirror_05", {24'h0, color_out[47:24]}, 48'h0);
        chk("nomirror_04_05", color_out0, 48'h0);
        rd2(5'h14, 5'h15);
        chk("mirror_14_15", color_out, {24'hABCDEF, 24'h123456});
        chk("nomirror_14_15", color_out0, {24'hABCDEF, 24'h123456});

        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 24'h111111; rd_addr = {5'd7, 5'd3};
        tick();
        wr_valid = 1'b0;
        tick();
        chk("collide_old", {24'h0, color_out[23:0]}, 48'h0000FF);
        tick();
        chk("collide_new", {24'h0, color_out[23:0]}, 48'h111111);
        palette_en = 1'b0;
        repeat (2) tick();
        chk("en_off", color_out, 48'h0);
        palette_en = 1'b1;

        wr1(5'd0, 24'hFFFFFF);
        rd_addr = {5'd7, 5'd0};
        run_fade(4'd7, 16'd3, n);
        chk("fade_cycles", 48'(n), 48'd32);
        chk("fade_level", {44'h0, brightness}, 48'd7);
        repeat (2) tick();
        chk("fade_color", color_out, {24'h7F0000, 24'h7F7F7F});
        fade_target = 4'd7; fade_start = 1'b1;
        tick();
        fade_start = 1'b0;
        chk("same_target_busy", {47'h0, fade_busy}, 48'd0);
        run_fade(4'd0, 16'd0, n);
        chk("fade0_cycles", 48'(n), 48'd7);
        repeat (2) tick();
        chk("dim_color", {24'h0, color_out[23:0]}, 48'h0F0F0F);

        fade_target = 4'd15; fade_period = 16'd3; fade_start = 1'b1;
        tick();
        fade_start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_bright", {44'h0, brightness}, 48'd15);
        chk("mid_rst_busy", {47'h0, fade_busy}, 48'd0);
        chk("mid_rst_ready", {47'h0, wr_ready}, 48'd0);
        tick();
        rst = 1'b0;
        wait_init();
        rd2(5'd3, 5'd7);
        chk("reinit_3_7", color_out, 48'h0);
        rd2(5'd0, 5'h14);
        chk("reinit_0_14", color_out, 48'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
